// File: rtl/alu_bist_driver.sv
// Built-in self-test driver for the single-cycle ALU: runs directed and LFSR vectors through every aluop.
// Latency: 13 cycles per vector; backpressure: none, start is ignored while busy.
module alu_bist_driver #(
  parameter int          NUM_RAND = 16,
  parameter logic [31:0] SEED     = 32'hACE1_2345
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_res,
  input  logic        alu_zero,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] fail_count,
  output logic [10:0] first_fail_idx,
  output logic [3:0]  first_fail_op
);

  localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [10:0] LAST_IDX  = 11'(4 + NUM_RAND);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRIVE, S_CHECK, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [10:0] vec_idx;
  logic [2:0]  op_idx;
  logic [31:0] lfsr;
  logic [31:0] lfsr_1;
  logic [31:0] exp_res;
  logic        exp_zero;
  logic [3:0]  drive_op;
  logic [31:0] drive_res;
  logic        accept;
  logic        mismatch;
  logic        last_op;
  logic        last_vec;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

  function automatic logic [3:0] op_code(input logic [2:0] i);
    case (i)
      3'd0:    return 4'd0;
      3'd1:    return 4'd1;
      3'd2:    return 4'd2;
      3'd3:    return 4'd6;
      3'd4:    return 4'd7;
      default: return 4'd12;
    endcase
  endfunction

  function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12:   return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  assign lfsr_1    = lfsr_step(lfsr);
  assign drive_op  = op_code(op_idx);
  assign drive_res = golden(alu_a, alu_b, drive_op);
  assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
  // Result and zero mismatching together still count once.
  assign mismatch  = (alu_res != exp_res) || (alu_zero != exp_zero);
  assign last_op   = (op_idx == 3'd5);
  assign last_vec  = (vec_idx == LAST_IDX);

  assign busy = (state == S_LOAD) || (state == S_DRIVE) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (fail_count == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (accept) state_nxt = S_LOAD;
      S_LOAD:         state_nxt = S_DRIVE;
      S_DRIVE:        state_nxt = S_CHECK;
      S_CHECK: begin
        if (!last_op)       state_nxt = S_DRIVE;
        else if (!last_vec) state_nxt = S_LOAD;
        else                state_nxt = S_DONE;
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a          <= 32'd0;
      alu_b          <= 32'd0;
      alu_op         <= 4'd0;
      fail_count     <= 16'd0;
      first_fail_idx <= 11'd0;
      first_fail_op  <= 4'd0;
      vec_idx        <= 11'd0;
      op_idx         <= 3'd0;
      lfsr           <= SEED_EFF;
      exp_res        <= 32'd0;
      exp_zero       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // LFSR deliberately kept so back-to-back runs see fresh random vectors.
          if (accept) begin
            fail_count     <= 16'd0;
            first_fail_idx <= 11'd0;
            first_fail_op  <= 4'd0;
            vec_idx        <= 11'd0;
            op_idx         <= 3'd0;
          end
        end
        S_LOAD: begin
          op_idx <= 3'd0;
          case (vec_idx)
            11'd0: begin alu_a <= 32'd6;          alu_b <= 32'd3;          end
            11'd1: begin alu_a <= 32'd6;          alu_b <= 32'd7;          end
            11'd2: begin alu_a <= 32'd0;          alu_b <= 32'd0;          end
            11'd3: begin alu_a <= 32'h8000_0000;  alu_b <= 32'd1;          end
            11'd4: begin alu_a <= 32'h7FFF_FFFF;  alu_b <= 32'hFFFF_FFFF;  end
            default: begin
              alu_a <= lfsr;
              alu_b <= lfsr_1;
              lfsr  <= lfsr_step(lfsr_1);
            end
          endcase
        end
        S_DRIVE: begin
          alu_op   <= drive_op;
          exp_res  <= drive_res;
          exp_zero <= (drive_res == 32'd0);
        end
        S_CHECK: begin
          if (mismatch) begin
            if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
            if (fail_count == 16'd0) begin
              first_fail_idx <= vec_idx;
              first_fail_op  <= alu_op;
            end
          end
          if (!last_op)       op_idx  <= op_idx + 3'd1;
          else if (!last_vec) vec_idx <= vec_idx + 11'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
